// File: rtl/binary_frame_downscaler_if.sv
// Pixel stream from the camera reader in, packed grid rows to the constraint generator out.
interface binary_frame_downscaler_if #(
    parameter int OUT_W = 40,
    parameter int IDX_W = 5
);
    logic [15:0]      pixel_in;
    logic             pixel_valid_in;
    logic             frame_done_in;
    logic [OUT_W-1:0] row_out;
    logic [IDX_W-1:0] row_index_out;
    logic             row_valid_out;
    logic             done_out;

    modport master (
        output pixel_in, pixel_valid_in, frame_done_in,
        input  row_out, row_index_out, row_valid_out, done_out
    );
    modport slave (
        input  pixel_in, pixel_valid_in, frame_done_in,
        output row_out, row_index_out, row_valid_out, done_out
    );
endinterface

// File: rtl/binary_frame_downscaler.sv
// Binarises an RGB565 frame (luma or single-colour) and majority-downscales it by SCALE x SCALE,
// emitting one packed grid row per pulse.
module binary_frame_downscaler #(
    parameter int IN_W   = 320,
    parameter int IN_H   = 240,
    parameter int SCALE  = 8,
    parameter int THRESH = 5,
    parameter int MAJ    = 32
) (
    input  logic       clk_in,
    input  logic       reset_in,
    input  logic       start_in,
    input  logic [1:0] mode_in,
    output logic       busy_out,
    output logic       short_frame_out,
    binary_frame_downscaler_if.slave bus
);
    localparam int OUT_W = IN_W / SCALE;
    localparam int OUT_H = IN_H / SCALE;
    localparam int XW    = $clog2(IN_W);
    localparam int YW    = $clog2(IN_H);
    localparam int CW    = $clog2(SCALE * SCALE + 1);
    // A single-row grid still needs a one-bit index port.
    localparam int IW    = (OUT_H > 1) ? $clog2(OUT_H) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_CAPT = 2'd2;
    localparam logic [1:0] ST_FIN  = 2'd3;

    logic [1:0]    state, mode;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [CW-1:0] cnt     [OUT_W];
    logic [CW-1:0] cnt_nxt [OUT_W];
    logic [OUT_W-1:0] row_bits;
    logic [3:0]    r, g, b;
    logic [4:0]    luma;
    logic          pix_bit, acc, x_last, band_end, last_pix;
    logic          pix_unused;

    assign r = bus.pixel_in[15:12];
    assign g = bus.pixel_in[10:7];
    assign b = bus.pixel_in[4:1];
    assign pix_unused = ^{bus.pixel_in[11], bus.pixel_in[6:5], bus.pixel_in[0]};
    assign luma = 5'(r[3:2]) + 5'(g[3:1]) + 5'(b[3:2]);

    always_comb begin
        pix_bit = 1'b0;
        case (mode)
            2'b00:   pix_bit = (luma <= 5'(THRESH));
            2'b01:   pix_bit = (r > 4'd8) && (g < 4'd8) && (b < 4'd8);
            2'b10:   pix_bit = (g > 4'd8) && (r < 4'd8) && (b < 4'd8);
            default: pix_bit = (b > 4'd8) && (r < 4'd8) && (g < 4'd8);
        endcase
    end

    assign acc      = (state == ST_CAPT) && bus.pixel_valid_in;
    assign x_last   = (x == XW'(IN_W - 1));
    assign band_end = ((int'(y) % SCALE) == SCALE - 1);
    assign last_pix = x_last && (y == YW'(IN_H - 1));

    // The emitted row includes the pixel accepted on the emitting edge.
    always_comb begin
        for (int i = 0; i < OUT_W; i++) begin
            cnt_nxt[i] = cnt[i] + (((int'(x) / SCALE) == i && pix_bit) ? CW'(1) : CW'(0));
            row_bits[OUT_W-1-i] = (cnt_nxt[i] > CW'(MAJ));
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state             <= ST_IDLE;
            mode              <= 2'b00;
            x                 <= '0;
            y                 <= '0;
            busy_out          <= 1'b0;
            short_frame_out   <= 1'b0;
            bus.row_out       <= '0;
            bus.row_index_out <= '0;
            bus.row_valid_out <= 1'b0;
            bus.done_out      <= 1'b0;
            for (int i = 0; i < OUT_W; i++) cnt[i] <= '0;
        end else begin
            bus.row_valid_out <= 1'b0;
            bus.done_out      <= 1'b0;
            case (state)
                ST_IDLE: if (start_in) begin
                    mode            <= mode_in;
                    short_frame_out <= 1'b0;
                    busy_out        <= 1'b1;
                    state           <= ST_WAIT;
                end
                ST_WAIT: if (bus.frame_done_in) begin
                    x     <= '0;
                    y     <= '0;
                    state <= ST_CAPT;
                    for (int i = 0; i < OUT_W; i++) cnt[i] <= '0;
                end
                ST_CAPT: begin
                    if (bus.frame_done_in && !(acc && last_pix)) begin
                        short_frame_out <= 1'b1;
                        busy_out        <= 1'b0;
                        state           <= ST_IDLE;
                    end else if (acc) begin
                        for (int i = 0; i < OUT_W; i++) cnt[i] <= cnt_nxt[i];
                        x <= x_last ? '0 : x + 1'b1;
                        if (x_last) y <= y + 1'b1;
                        if (x_last && band_end) begin
                            bus.row_out       <= row_bits;
                            bus.row_index_out <= IW'(int'(y) / SCALE);
                            bus.row_valid_out <= 1'b1;
                            for (int i = 0; i < OUT_W; i++) cnt[i] <= '0;
                        end
                        if (last_pix) state <= ST_FIN;
                    end
                end
                default: begin
                    bus.done_out <= 1'b1;
                    busy_out     <= 1'b0;
                    state        <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_binary_frame_downscaler.sv
// Scoreboard bench for a 16x16 frame downscaled by 8 into a 2x2 grid.
module tb_binary_frame_downscaler;
  localparam int IN_W = 16, IN_H = 16, SCALE = 8, THRESH = 5, MAJ = 32;
  localparam int OUT_W = IN_W / SCALE;

  logic       clk = 1'b0;
  logic       reset_in, start_in;
  logic [1:0] mode_in;
  logic       busy_out, short_frame_out;

  always #5 clk = ~clk;

  binary_frame_downscaler_if #(.OUT_W(OUT_W), .IDX_W(1)) bus ();

  binary_frame_downscaler #(
    .IN_W(IN_W), .IN_H(IN_H), .SCALE(SCALE), .THRESH(THRESH), .MAJ(MAJ)
  ) dut (
    .clk_in(clk), .reset_in(reset_in), .start_in(start_in), .mode_in(mode_in),
    .busy_out(busy_out), .short_frame_out(short_frame_out), .bus(bus)
  );

  int         n_chk = 0, n_err = 0, done_seen = 0;
  logic [2:0] sb[$];
  int         tx, ty;
  int         tcnt[OUT_W];
  logic [1:0] tmode;
  logic       prev_rv = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  function automatic logic classify(input logic [15:0] p, input logic [1:0] m);
    int r = int'(p[15:12]);
    int g = int'(p[10:7]);
    int b = int'(p[4:1]);
    case (m)
      2'b00:   return (r / 4 + g / 2 + b / 4) <= THRESH;
      2'b01:   return r > 8 && g < 8 && b < 8;
      2'b10:   return g > 8 && r < 8 && b < 8;
      default: return b > 8 && r < 8 && g < 8;
    endcase
  endfunction

  function automatic logic [15:0] pat(input int kind, input int x, input int y);
    int rr  = $urandom_range(0, 99);
    int pct = 40 + 15 * ((x / 8 + y / 8) % 3);
    case (kind)
      0: return 16'h0000;
      1: return (x < 8) ? 16'hFFFF : 16'h0000;
      2: if (x >= 8) return 16'h0000;
         else if (y < 8) return (y * 8 + x < 32) ? 16'h0000 : 16'hFFFF;
         else return ((y - 8) * 8 + x < 33) ? 16'h0000 : 16'hFFFF;
      3: return (x < 8) ? 16'hF000 : 16'hF7DE;
      default: return (rr < pct) ? 16'h0000 : (rr < 90) ? 16'hFFFF : 16'($urandom);
    endcase
  endfunction

  // drive one valid pixel and advance the reference model
  task automatic send_px(input logic [15:0] p, input logic fd);
    bus.pixel_in = p; bus.pixel_valid_in = 1'b1; bus.frame_done_in = fd;
    if (classify(p, tmode)) tcnt[tx / SCALE]++;
    if (tx == IN_W - 1 && ty % SCALE == SCALE - 1) begin
      sb.push_back({1'(ty / SCALE), 1'(tcnt[0] > MAJ), 1'(tcnt[1] > MAJ)});
      for (int i = 0; i < OUT_W; i++) tcnt[i] = 0;
    end
    tx++;
    if (tx == IN_W) begin tx = 0; ty++; end
    tick;
    bus.pixel_valid_in = 1'b0; bus.frame_done_in = 1'b0;
  endtask

  // start pulse, then a frame boundary carrying a pixel that must be dropped
  task automatic start_frame(input logic [1:0] m);
    mode_in = m; start_in = 1'b1; tick; start_in = 1'b0;
    chk("start_busy", busy_out, 1);
    chk("start_short_clr", short_frame_out, 0);
    bus.frame_done_in = 1'b1; bus.pixel_valid_in = 1'b1; bus.pixel_in = 16'hFFFF;
    tick;
    bus.frame_done_in = 1'b0; bus.pixel_valid_in = 1'b0;
    tmode = m; tx = 0; ty = 0;
    for (int i = 0; i < OUT_W; i++) tcnt[i] = 0;
  endtask

  task automatic run_frame(input int kind, input logic [1:0] m, input bit gaps, input bit disturb);
    int d0;
    start_frame(m);
    d0 = done_seen;
    for (int i = 0; i < IN_W * IN_H; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick;
      if (disturb && i == 100) begin start_in = 1'b1; mode_in = 2'b11; end
      send_px(pat(kind, i % IN_W, i / IN_W), i == IN_W * IN_H - 1);
      start_in = 1'b0;
    end
    chk("lat_row", bus.row_valid_out, 1);
    bus.pixel_valid_in = 1'b1; bus.pixel_in = 16'h0000;
    tick;
    bus.pixel_valid_in = 1'b0;
    chk("lat_done", bus.done_out, 1);
    chk("busy_drop", busy_out, 0);
    repeat (3) tick;
    chk("done_once", done_seen, d0 + 1);
    chk("sb_empty", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (bus.row_valid_out) begin
      if (sb.size() == 0) chk("row_unexp", bus.row_valid_out, 0);
      else chk("row", {bus.row_index_out, bus.row_out}, sb.pop_front());
    end
    if (bus.done_out) begin
      done_seen++;
      chk("done_after_row", prev_rv, 1);
      chk("done_excl", bus.row_valid_out, 0);
    end
    prev_rv = bus.row_valid_out;
  end

  initial begin
    int d0;
    reset_in = 1'b1; start_in = 1'b0; mode_in = 2'b00;
    bus.pixel_in = '0; bus.pixel_valid_in = 1'b0; bus.frame_done_in = 1'b0;
    repeat (3) tick;
    chk("rst_busy", busy_out, 0);
    chk("rst_short", short_frame_out, 0);
    chk("rst_rv", bus.row_valid_out, 0);
    chk("rst_done", bus.done_out, 0);
    chk("rst_row", {bus.row_index_out, bus.row_out}, 0);
    reset_in = 1'b0;
    tick;

    run_frame(0, 2'b00, 1'b0, 1'b0);   // all black
    run_frame(1, 2'b00, 1'b0, 1'b0);   // left white, right black
    run_frame(2, 2'b00, 1'b0, 1'b0);   // 32 vs 33 black pixels in block 0
    run_frame(3, 2'b01, 1'b0, 1'b1);   // red mode, mode change + start mid-frame

    // short frame abort
    start_frame(2'b00);
    d0 = done_seen;
    for (int i = 0; i < 70; i++) send_px(16'h0000, 1'b0);
    bus.frame_done_in = 1'b1; tick; bus.frame_done_in = 1'b0;
    chk("abort_short", short_frame_out, 1);
    chk("abort_busy", busy_out, 0);
    repeat (3) tick;
    chk("abort_no_done", done_seen, d0);
    chk("abort_sb", sb.size(), 0);
    run_frame(4, 2'b00, 1'b1, 1'b0);   // random content with valid gaps
    run_frame(4, 2'b00, 1'b1, 1'b0);

    // reset mid-frame, then a clean frame
    start_frame(2'b00);
    for (int i = 0; i < 50; i++) send_px(16'h0000, 1'b0);
    reset_in = 1'b1; tick;
    chk("midrst_busy", busy_out, 0);
    chk("midrst_rv", bus.row_valid_out, 0);
    reset_in = 1'b0; tick;
    run_frame(0, 2'b00, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
